aes_sub_shifter: RTL and testbench
==================================

# aes_sub_shifter

Iterative SubBytes + ShiftRows stage (or InvShiftRows + InvSubBytes when decrypting) that feeds the column-mixing stage of the AES round datapath. It accepts one 128-bit state per valid/ready handshake and substitutes one column (four bytes) per clock with four shared S-box lookups. It presents the permuted, substituted state on a registered output held until the consumer accepts it. Both directions share one datapath, selected by `Encrypt`, which is latched at acceptance.

## Interface
- No parameters; widths come from `AES_BLOCK_SIZE` (128) and `AES_WORD_SIZE` (32) in aes_defines.svh.
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous reset, active-high
- Encrypt  input  1  1 = SubBytes/ShiftRows, 0 = InvShiftRows/InvSubBytes; sampled on acceptance
- In_valid  input  1  Input_block is valid
- In_ready  output  1  stage can accept a block this cycle
- Input_block  input  128  state in; byte i at [127-8i -: 8], column c = bytes 4c..4c+3, row r = i mod 4
- Out_valid  output  1  Output_block holds a finished result
- Out_ready  input  1  consumer accepts Output_block
- Output_block  output  128  processed state, same byte layout

## Operation
- Transfer occurs on a rising edge where valid & ready are both 1, on either side.
- Forward: out[r][c] = S(in[r][(c+r) mod 4]). Inverse: out[r][c] = InvS(in[r][(c-r) mod 4]).
- S(b): GF(2^8) multiplicative inverse mod x^8+x^4+x^3+x+1 (0 maps to 0), then the FIPS-197 affine transform with constant 0x63. InvS(b): inverse affine with constant 0x05, then multiplicative inverse. Both are combinational, four instances, and no ROM.
- States:
  - IDLE: In_ready=1. On acceptance, capture Input_block and Encrypt, set col=0, go to BUSY.
  - BUSY: each cycle, substitute the four bytes of captured input column col and write them to their shifted destinations in the output register; col increments. After col=3 is written, go to DONE.
  - DONE: Out_valid=1. On Out_ready, go to IDLE, or go to BUSY if a new block is accepted the same edge.
- In_ready = (state==IDLE) | (state==DONE & Out_ready), giving zero-bubble back-to-back operation.
- col is a 2-bit counter that wraps 3→0 only on entry to BUSY.
- The Encrypt input is ignored outside acceptance; the latched copy governs the whole block.
- Output_block is stable for all DONE cycles. It changes only during BUSY, when Out_valid=0.
- Rst in any state, including mid-BUSY, abandons the block and emits no output.

## Timing
- Reset values: state IDLE, Out_valid 0, Output_block 128'h0, col 0, latched Encrypt 1, In_ready 1 (comb from IDLE).
- Latency: acceptance at edge E; columns are written at edges E+1..E+4; Out_valid is high from the cycle after E+4.
- Throughput: one block per 5 cycles with Out_ready held 1.
- Backpressure: with Out_ready=0, DONE holds indefinitely and In_ready=0.
- In_valid and Out_ready asserted in the same DONE cycle: the output transfer and the new input acceptance happen at that same edge.
- No combinational path from Out_ready to Output_block or Out_valid. In_ready depends combinationally on Out_ready only.

## Test plan
- Encrypt=1, input 128'h193de3bea0f4e22b9ac68d2ae9f84808 -> 128'hd4bf5d30e0b452aeb84111f11e2798e5, Out_valid rises exactly 5 cycles after the In_valid cycle.
- Encrypt=0, input 128'hd4bf5d30e0b452aeb84111f11e2798e5 -> 128'h193de3bea0f4e22b9ac68d2ae9f84808.
- All-zero input: Encrypt=1 -> all bytes 8'h63; Encrypt=0 -> all bytes 8'h52.
- Hold Out_ready=0 for 10 cycles after DONE -> Output_block and Out_valid stable, In_ready=0, In_valid ignored. Then raise Out_ready with In_valid=1 -> the result is consumed and the next block accepted at the same edge.
- Toggle Encrypt during BUSY -> result still follows the value latched at acceptance.
- Assert Rst at the 2nd BUSY cycle -> next cycle state IDLE, Out_valid 0, Output_block 0, In_ready 1; the following block is processed correctly.

Source files
------------

// File: rtl/aes_sub_shifter.sv
// aes_sub_shifter: iterative SubBytes+ShiftRows (or InvShiftRows+InvSubBytes)
// stage. It accepts one 128-bit state per handshake and substitutes one column
// per clock through four shared S-box units. The permuted result is held in a
// registered output until the consumer accepts it.
module aes_sub_shifter (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Encrypt,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [127:0] Input_block,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [127:0] Output_block
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [1:0]   col_r;
    logic         enc_r;
    logic [127:0] in_r;
    logic [127:0] out_r;
    logic         out_valid_r;
    logic         in_ready_s;
    logic         accept_s;
    logic [7:0]   sub_s [4];
    logic [1:0]   dst_s [4];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ 8'h1b;
            end else begin
                aa = {aa[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0 naturally)
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] r;
        x = gf_mul(b, b);
        r = x;
        for (int i = 0; i < 6; i++) begin
            x = gf_mul(x, x);
            r = gf_mul(r, x);
        end
        return r;
    endfunction

    // Forward affine transform: b ^ rotl1..rotl4 ^ 0x63
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // One S-box unit serving both directions around a single field inverter
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic enc);
        logic [7:0] pre;
        logic [7:0] t;
        if (enc) begin
            pre = b;
        end else begin
            pre = inv_affine(b);
        end
        t = gf_inv(pre);
        if (enc) begin
            return fwd_affine(t);
        end else begin
            return t;
        end
    endfunction

    assign in_ready_s   = (state_r == ST_IDLE) | ((state_r == ST_DONE) & Out_ready);
    assign accept_s     = In_valid & in_ready_s;
    assign In_ready     = in_ready_s;
    assign Out_valid    = out_valid_r;
    assign Output_block = out_r;

    // Substitute the current captured column and compute each row's shifted destination column
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            sub_s[r] = sub_byte(in_r[{~{col_r, 2'(r)}, 3'b111} -: 8], enc_r);
            if (enc_r) begin
                dst_s[r] = col_r - 2'(r);
            end else begin
                dst_s[r] = col_r + 2'(r);
            end
        end
    end

    // Next-state logic for IDLE / BUSY / DONE sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (In_valid) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (col_r == 2'd3) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (Out_ready) begin
                    if (In_valid) begin
                        state_s = ST_BUSY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture on acceptance, write one substituted column per BUSY cycle, register Out_valid
    always_ff @(posedge Clk) begin
        if (Rst) begin
            in_r        <= 128'h0;
            enc_r       <= 1'b1;
            col_r       <= 2'd0;
            out_r       <= 128'h0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_s == ST_DONE);
            if (accept_s) begin
                in_r  <= Input_block;
                enc_r <= Encrypt;
                col_r <= 2'd0;
            end else if (state_r == ST_BUSY) begin
                // col parks at 3 in DONE; it only restarts at 0 on the next acceptance
                if (col_r == 2'd3) begin
                    col_r <= col_r;
                end else begin
                    col_r <= col_r + 2'd1;
                end
                for (int r = 0; r < 4; r++) begin
                    out_r[{~{dst_s[r], 2'(r)}, 3'b111} -: 8] <= sub_s[r];
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

endmodule

// File: tb/tb_aes_sub_shifter.sv
// Self-checking bench for aes_sub_shifter: a vector table plus hand-written
// sequences for backpressure, Encrypt toggling, mid-block reset and throughput.
module tb_aes_sub_shifter;

    logic         Clk;
    logic         Rst;
    logic         Encrypt;
    logic         In_valid;
    logic         In_ready;
    logic [127:0] Input_block;
    logic         Out_valid;
    logic         Out_ready;
    logic [127:0] Output_block;

    aes_sub_shifter dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Encrypt      (Encrypt),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .Input_block  (Input_block),
        .Out_valid    (Out_valid),
        .Out_ready    (Out_ready),
        .Output_block (Output_block)
    );

    typedef struct {
        logic         enc;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] R2_IN    = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] R2_OUT   = 128'h49db873b453953897f02d2f177de961a;

    vec_t         vecs [9];
    sb_t          sb [$];
    logic [127:0] cur_exp;
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic         ov_prev = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: push on acceptance, pop/compare on output transfer, check latency
    always @(negedge Clk) begin
        if (Rst) begin
            sb.delete();
        end else begin
            if (Out_valid && !ov_prev) begin
                if (sb.size() > 0) begin
                    check("latency", 128'(cyc - sb[0].acc), 128'd5);
                end else begin
                    check("spurious_out_valid", {127'd0, Out_valid}, 128'd0);
                end
            end
            if (Out_valid && Out_ready) begin
                if (sb.size() > 0) begin
                    check("data", Output_block, sb[0].exp);
                    void'(sb.pop_front());
                end else begin
                    check("spurious_transfer", {127'd0, Out_valid}, 128'd0);
                end
            end
            if (In_valid && In_ready) begin
                sb.push_back('{exp: cur_exp, acc: cyc});
            end
        end
        ov_prev <= Out_valid;
    end

    // Drive one block and wait (bounded) for its acceptance; returns at posedge+1
    task automatic send(input logic enc, input logic [127:0] blk, input logic [127:0] exp,
                        output int acc);
        Encrypt     = enc;
        Input_block = blk;
        cur_exp     = exp;
        In_valid    = 1'b1;
        acc         = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (In_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("accept_timeout", {127'd0, In_ready}, 128'd1);
        end
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty
    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 128'(sb.size()), 128'd0);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc;
        int acc0;
        int acc1;
        int acc2;

        vecs[0] = '{1'b1, FIPS_IN,           FIPS_OUT};
        vecs[1] = '{1'b0, FIPS_OUT,          FIPS_IN};
        vecs[2] = '{1'b1, 128'h0,            {16{8'h63}}};
        vecs[3] = '{1'b0, 128'h0,            {16{8'h52}}};
        vecs[4] = '{1'b1, {16{8'hff}},       {16{8'h16}}};
        vecs[5] = '{1'b0, {16{8'h16}},       {16{8'hff}}};
        vecs[6] = '{1'b1, R2_IN,             R2_OUT};
        vecs[7] = '{1'b0, R2_OUT,            R2_IN};
        vecs[8] = '{1'b1, {16{8'h53}},       {16{8'hed}}};

        Rst         = 1'b1;
        Encrypt     = 1'b1;
        In_valid    = 1'b0;
        Input_block = 128'h0;
        Out_ready   = 1'b1;
        cur_exp     = 128'h0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_in_ready",  {127'd0, In_ready},  128'd1);
        check("reset_out_valid", {127'd0, Out_valid}, 128'd0);
        check("reset_out_block", Output_block,        128'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].enc, vecs[i].din, vecs[i].dout, acc);
            drain();
        end

        // Backpressure: hold DONE, then consume and accept at the same edge
        Out_ready = 1'b0;
        send(1'b1, FIPS_IN, FIPS_OUT, acc);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Out_valid) break;
        end
        @(posedge Clk);
        #1;
        Encrypt     = 1'b0;
        Input_block = 128'h0;
        cur_exp     = {16{8'h52}};
        In_valid    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            check("bp_out_valid", {127'd0, Out_valid}, 128'd1);
            check("bp_out_block", Output_block,        FIPS_OUT);
            check("bp_in_ready",  {127'd0, In_ready},  128'd0);
        end
        @(posedge Clk);
        #1;
        Out_ready = 1'b1;
        @(negedge Clk);
        check("bp_release_in_ready", {127'd0, In_ready}, 128'd1);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        @(negedge Clk);
        check("bp_busy_out_valid", {127'd0, Out_valid}, 128'd0);
        drain();

        // Toggle Encrypt during BUSY: latched value governs
        send(1'b1, FIPS_IN, FIPS_OUT, acc);
        for (int k = 0; k < 4; k++) begin
            Encrypt = ~Encrypt;
            @(posedge Clk);
            #1;
        end
        drain();

        // Reset at the 2nd BUSY cycle abandons the block
        send(1'b0, FIPS_OUT, FIPS_IN, acc);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_busy_in_ready",  {127'd0, In_ready},  128'd1);
        check("rst_busy_out_valid", {127'd0, Out_valid}, 128'd0);
        check("rst_busy_out_block", Output_block,        128'h0);
        repeat (6) @(negedge Clk);
        check("rst_busy_no_output", {127'd0, Out_valid}, 128'd0);
        @(posedge Clk);
        #1;
        send(1'b1, R2_IN, R2_OUT, acc);
        drain();

        // Throughput: back-to-back blocks with Out_ready held high
        send(1'b1, FIPS_IN,  FIPS_OUT,    acc0);
        send(1'b0, FIPS_OUT, FIPS_IN,     acc1);
        send(1'b1, 128'h0,   {16{8'h63}}, acc2);
        check("throughput_gap1", 128'(acc1 - acc0), 128'd5);
        check("throughput_gap2", 128'(acc2 - acc1), 128'd5);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
